// File: rtl/life_grid_store.sv
`default_nettype none
// ============================================================================
// Module   : life_grid_store
// Brief    : Life-engine cell store. The grid is one circular shift register
//            with pipeline write-back, serial host load, hold and clear, plus
//            sweep, generation and live-cell counters.
// Revision : 1.0 - initial release
// ============================================================================
module life_grid_store #(
    parameter int X     = 8,
    parameter int Y     = 8,
    parameter int LOG2X = 3,
    parameter int LOG2Y = 3,
    parameter int LAG   = 4,
    parameter int GEN_W = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [1:0]             mode,
    input  logic                   load_bit,
    input  logic                   pipe_out,
    output logic [X*Y-1:0]         data,
    output logic [LOG2X+LOG2Y-1:0] cell_idx,
    output logic                   gen_done,
    output logic                   load_done,
    output logic [GEN_W-1:0]       gen_count,
    output logic [LOG2X+LOG2Y:0]   alive_count
);

    localparam int c_CELLS  = X * Y;
    localparam int c_IDX_W  = LOG2X + LOG2Y;
    localparam int c_CNT_W  = c_IDX_W + 1;
    localparam int c_WB_IDX = (Y - 1) * X - LAG;

    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(c_CELLS - 1);

    localparam logic [1:0] c_MODE_HOLD  = 2'b00;
    localparam logic [1:0] c_MODE_RUN   = 2'b01;
    localparam logic [1:0] c_MODE_LOAD  = 2'b10;
    localparam logic [1:0] c_MODE_CLEAR = 2'b11;

    generate
        if (LAG < 1 || LAG > (Y - 1) * X - 1 || c_CELLS > (1 << c_IDX_W)) begin : g_bad_params
            $error("life_grid_store: LAG must lie in 1..(Y-1)*X-1 and X*Y must fit in LOG2X+LOG2Y bits");
        end
    endgenerate

    logic [c_CELLS-1:0] r_data;
    logic [c_IDX_W-1:0] r_cell_idx;
    logic               r_gen_done;
    logic               r_load_done;
    logic [GEN_W-1:0]   r_gen_count;
    logic [c_CNT_W-1:0] r_alive;
    logic               r_in_load;

    logic [c_CELLS-1:0] w_data_nxt;
    logic [c_IDX_W-1:0] w_idx_base;
    logic [c_IDX_W-1:0] w_idx_nxt;
    logic [c_CNT_W-1:0] w_alive_nxt;
    logic               w_in_bit;
    logic               w_out_bit;
    logic               w_wrap;

    always_comb begin
        w_data_nxt = r_data;
        w_in_bit   = 1'b0;
        w_out_bit  = 1'b0;
        // A fresh LOAD sweep treats the current edge as position 0.
        w_idx_base = (mode == c_MODE_LOAD && !r_in_load) ? '0 : r_cell_idx;
        w_wrap     = (w_idx_base == c_LAST_IDX);
        w_idx_nxt  = w_wrap ? '0 : w_idx_base + 1'b1;
        case (mode)
            c_MODE_RUN: begin
                w_data_nxt           = {r_data[0], r_data[c_CELLS-1:1]};
                w_data_nxt[c_WB_IDX] = pipe_out;
                w_in_bit             = pipe_out;
                w_out_bit            = r_data[c_WB_IDX+1];
            end
            c_MODE_LOAD: begin
                w_data_nxt = {load_bit, r_data[c_CELLS-1:1]};
                w_in_bit   = load_bit;
                w_out_bit  = r_data[0];
            end
            default: ;
        endcase
        // Only the bit entering and the bit leaving can change the popcount.
        w_alive_nxt = r_alive + c_CNT_W'(w_in_bit) - c_CNT_W'(w_out_bit);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data      <= '0;
            r_cell_idx  <= '0;
            r_gen_done  <= 1'b0;
            r_load_done <= 1'b0;
            r_gen_count <= '0;
            r_alive     <= '0;
            r_in_load   <= 1'b0;
        end else begin
            r_gen_done  <= 1'b0;
            r_load_done <= 1'b0;
            r_in_load   <= (mode == c_MODE_LOAD);
            case (mode)
                c_MODE_RUN: begin
                    r_data     <= w_data_nxt;
                    r_alive    <= w_alive_nxt;
                    r_cell_idx <= w_idx_nxt;
                    if (w_wrap) begin
                        r_gen_done  <= 1'b1;
                        r_gen_count <= r_gen_count + 1'b1;
                    end
                end
                c_MODE_LOAD: begin
                    r_data      <= w_data_nxt;
                    r_alive     <= w_alive_nxt;
                    r_cell_idx  <= w_idx_nxt;
                    r_load_done <= w_wrap;
                end
                c_MODE_CLEAR: begin
                    r_data      <= '0;
                    r_alive     <= '0;
                    r_cell_idx  <= '0;
                    r_gen_count <= '0;
                end
                default: ;
            endcase
        end
    end

    assign data        = r_data;
    assign cell_idx    = r_cell_idx;
    assign gen_done    = r_gen_done;
    assign load_done   = r_load_done;
    assign gen_count   = r_gen_count;
    assign alive_count = r_alive;

endmodule
`default_nettype wire
